// File: rtl/digit_buf_pkg.sv
// Shared digit-buffer dimensions, reused by the UART decoder and the display path.
package digit_buf_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned DIGIT_DEPTH = 8;

endpackage

// File: rtl/nibble_digit_buffer.sv
// Right-aligned digit register buffer with addressed write, push/pop shift entry,
// an occupancy count and a one-cycle error pulse for rejected operations.
module nibble_digit_buffer
  import digit_buf_pkg::*;
#(
  parameter int unsigned WIDTH = DIGIT_W,
  parameter int unsigned DEPTH = DIGIT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [AW-1:0]          addr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [DEPTH*WIDTH-1:0] data_out,
  output logic [AW:0]            count,
  output logic                   full,
  output logic                   empty,
  output logic                   err
);

  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);
  localparam logic [AW:0] CntOne  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [AW:0]      r_count;
  logic             r_err;

  logic [WIDTH-1:0] w_shl [0:DEPTH-1];
  logic [WIDTH-1:0] w_shr [0:DEPTH-1];
  logic             w_full;
  logic             w_empty;
  logic             w_addr_ok;
  logic             w_push_op;

  assign w_full  = (r_count == FullCnt);
  assign w_empty = (r_count == '0);

  // Push+pop on an empty buffer degenerates to a plain push.
  assign w_push_op = push && (!pop || w_empty);

  assign w_shl[DEPTH-1] = wr_data;
  assign w_shr[0]       = '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_shift
    if (i < DEPTH - 1) begin : g_left
      assign w_shl[i] = r_mem[i+1];
    end
    if (i > 0) begin : g_right
      assign w_shr[i] = r_mem[i-1];
    end
    assign data_out[(DEPTH-1-i)*WIDTH +: WIDTH] = r_mem[i];
  end

  if ((1 << AW) == DEPTH) begin : g_addr_pow2
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_range
    assign w_addr_ok = ({1'b0, addr} < FullCnt);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_push_op) begin
      if (w_full) begin
        r_err <= 1'b1;
      end else begin
        r_mem   <= w_shl;
        r_count <= r_count + CntOne;
        r_err   <= wr_en;
      end
    end else if (push && pop) begin
      r_mem[DEPTH-1] <= wr_data;
      r_err          <= wr_en;
    end else if (pop) begin
      if (w_empty) begin
        r_err <= 1'b1;
      end else begin
        r_mem   <= w_shr;
        r_count <= r_count - CntOne;
        r_err   <= wr_en;
      end
    end else if (wr_en) begin
      if (w_addr_ok) begin
        r_mem[addr] <= wr_data;
      end
      r_err <= !w_addr_ok;
    end else begin
      r_err <= 1'b0;
    end
  end

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;
  assign err   = r_err;

endmodule

// File: tb/tb_nibble_digit_buffer.sv
// Bench for nibble_digit_buffer: directed scenarios plus random traffic against a
// model that treats the contents as one 32-bit right-justified digit string.
module tb_nibble_digit_buffer;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset, clear, wr_en, push, pop;
  logic [2:0]  addr;
  logic [3:0]  wr_data;
  logic [31:0] data_out;
  logic [3:0]  count;
  logic        full, empty, err;

  logic [31:0] m_data;
  int          m_cnt;
  logic        m_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nibble_digit_buffer #(.WIDTH(4), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (wr_en),
    .addr     (addr),
    .push     (push),
    .pop      (pop),
    .wr_data  (wr_data),
    .data_out (data_out),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: contents as a digit string, push = shift in at right, pop = drop rightmost.
  task automatic model(input logic rs, input logic cl, input logic we, input logic [2:0] a,
                       input logic ps, input logic pp, input logic [3:0] wd);
    m_err = 1'b0;
    if (rs || cl) begin
      m_data = '0;
      m_cnt  = 0;
    end else if (ps || pp) begin
      if (we) m_err = 1'b1;
      if (ps && pp && m_cnt >= 1) begin
        m_data = {m_data[31:4], wd};
      end else if (ps) begin
        if (m_cnt == D) m_err = 1'b1;
        else begin
          m_data = {m_data[27:0], wd};
          m_cnt++;
        end
      end else begin
        if (m_cnt == 0) m_err = 1'b1;
        else begin
          m_data = m_data >> 4;
          m_cnt--;
        end
      end
    end else if (we) begin
      m_data[(7 - int'(a)) * 4 +: 4] = wd;
    end
  endtask

  task automatic step(input logic rs, input logic cl, input logic we, input logic [2:0] a,
                      input logic ps, input logic pp, input logic [3:0] wd);
    reset = rs; clear = cl; wr_en = we; addr = a; push = ps; pop = pp; wr_data = wd;
    @(posedge clk);
    model(rs, cl, we, a, ps, pp, wd);
    #1;
    check("data_out", data_out, m_data);
    check("count", 32'(count), 32'(m_cnt));
    check("full", 32'(full), 32'(m_cnt == D));
    check("empty", 32'(empty), 32'(m_cnt == 0));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle();
    step(0, 0, 0, 3'd0, 0, 0, 4'd0);
  endtask

  task automatic do_push(input logic [3:0] wd);
    step(0, 0, 0, 3'd0, 1, 0, wd);
  endtask

  initial begin
    m_data = '0; m_cnt = 0; m_err = 1'b0;

    step(1, 0, 0, 3'd0, 0, 0, 4'd0);
    idle();
    check("rst_data", data_out, 32'h0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);

    do_push(4'd1); do_push(4'd2); do_push(4'd3);
    check("push123", data_out, 32'h0000_0123);
    check("push123_cnt", 32'(count), 32'd3);
    step(0, 0, 0, 3'd0, 0, 1, 4'd0);
    check("pop", data_out, 32'h0000_0012);

    step(0, 0, 0, 3'd0, 1, 1, 4'd7);
    check("replace", data_out, 32'h0000_0017);
    check("replace_err", 32'(err), 32'd0);

    step(0, 1, 0, 3'd0, 1, 0, 4'd5);
    check("clear", data_out, 32'h0);
    step(0, 0, 0, 3'd0, 1, 1, 4'd7);
    check("pp_empty", data_out, 32'h0000_0007);
    check("pp_empty_cnt", 32'(count), 32'd1);

    step(1, 0, 0, 3'd0, 0, 0, 4'd0);
    for (int i = 1; i <= 8; i++) do_push(4'(i));
    check("fill", data_out, 32'h1234_5678);
    check("fill_full", 32'(full), 32'd1);
    do_push(4'd9);
    check("overflow_err", 32'(err), 32'd1);
    check("overflow_data", data_out, 32'h1234_5678);
    idle();
    check("err_pulse", 32'(err), 32'd0);

    step(1, 0, 0, 3'd0, 0, 0, 4'd0);
    step(0, 0, 1, 3'd0, 0, 0, 4'hA);
    check("addr_wr", data_out, 32'hA000_0000);
    check("addr_wr_cnt", 32'(count), 32'd0);
    step(0, 0, 1, 3'd2, 1, 0, 4'h3);
    check("wr_push_err", 32'(err), 32'd1);
    check("wr_push_data", data_out, 32'h0000_0003);

    step(1, 0, 0, 3'd0, 0, 0, 4'd0);
    step(0, 0, 0, 3'd0, 0, 1, 4'd0);
    check("pop_empty_err", 32'(err), 32'd1);
    step(0, 0, 0, 3'd0, 0, 1, 4'd0);
    check("pop_empty_b2b", 32'(err), 32'd1);
    for (int i = 0; i < 5; i++) do_push(4'(i + 3));
    step(1, 0, 0, 3'd0, 1, 0, 4'hF);
    check("rst_mid", data_out, 32'h0);
    check("rst_mid_err", 32'(err), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      int r;
      logic rs, cl, we, ps, pp;
      r  = int'($urandom_range(0, 99));
      rs = (r == 0);
      cl = (r == 1);
      ps = ($urandom_range(0, 99) < 45);
      pp = ($urandom_range(0, 99) < 30);
      we = ($urandom_range(0, 99) < 30);
      step(rs, cl, we, 3'($urandom_range(0, 7)), ps, pp, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_digit_buffer.md
# nibble_digit_buffer

Parametrised register buffer of DEPTH entries, each WIDTH bits, with a flattened parallel output. It is the successor to the fixed 8×4-bit digit memory between the UART receive path and the display/compute logic. Two access modes are supported:
- **Addressed write:** random overwrite of one entry.
- **Calculator-style shift entry:** push appends a digit at the right, pop removes it (backspace).

An occupancy counter with full, empty and error flags lets the command FSM reject excess digits instead of silently corrupting them.

## Interface
Parameters:
- `WIDTH`, 4: bits per entry.
- `DEPTH`, 8: number of entries, ≥ 2.
- `AW`, `$clog2(DEPTH)`: address width (derived; do not override).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `clear`  in  1  synchronous flush of contents and count.
- `wr_en`  in  1  addressed write strobe.
- `addr`  in  AW  target entry for `wr_en`; index 0 is the leftmost/most-significant.
- `push`  in  1  shift-in strobe, uses `wr_data`.
- `pop`  in  1  shift-out (backspace) strobe.
- `wr_data`  in  WIDTH  data for `wr_en` and `push`.
- `data_out`  out  DEPTH*WIDTH  `{mem[0], mem[1], …, mem[DEPTH-1]}`, with `mem[0]` in the MSBs.
- `count`  out  AW+1  number of valid entries, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `err`  out  1  one-cycle pulse on a rejected operation.

## Operation
Entry model:
- Valid entries occupy `mem[DEPTH-count .. DEPTH-1]`, right-aligned.
- Unused entries hold 0.
- `data_out` is therefore directly usable as a right-justified digit string.

Per-cycle priority, highest first: `reset`, `clear`, `push`/`pop`, `wr_en`.
- **`reset` or `clear`:** all `mem` ← 0, `count` ← 0, `err` ← 0. All other inputs are ignored that cycle.
- **`push` only, not full:**
  - `mem[i]` ← `mem[i+1]` for i < DEPTH-1.
  - `mem[DEPTH-1]` ← `wr_data`.
  - `count` += 1.
- **`push` only, full:** no change; `err` ← 1.
- **`pop` only, not empty:**
  - `mem[i]` ← `mem[i-1]` for i > 0.
  - `mem[0]` ← 0.
  - `count` -= 1.
- **`pop` only, empty:** no change; `err` ← 1.
- **`push` and `pop` together:**
  - If `count` ≥ 1: replace the newest entry. `mem[DEPTH-1]` ← `wr_data`, `count` unchanged, no shift, no `err`.
  - If `count` == 0: behave as `push` only.
- **`wr_en` with no `push`/`pop`:** `mem[addr]` ← `wr_data`; `count` is unchanged, even when `addr` is outside the valid region.
- **`wr_en` with `push`/`pop`:** `wr_en` is ignored; `err` ← 1.
- **Otherwise:** state holds and `err` ← 0.
- `addr` ≥ DEPTH (possible only for non-power-of-2 DEPTH): the write is dropped; `err` ← 1.

## Timing
- All outputs are registered. An operation sampled at edge N is visible on `data_out`, `count`, `full`, `empty` and `err` after edge N; latency is 1 cycle.
- `full` and `empty` are decoded from the registered `count`, so they are valid in the same cycle as `count`.
- Reset values: `data_out` = 0, `count` = 0, `full` = 0, `empty` = 1, `err` = 0.
- `err` is high for exactly one cycle per offending edge. Back-to-back violations keep it high continuously.
- A `reset` asserted mid-sequence takes effect at the next edge regardless of pending strobes; nothing from that edge is committed.
- There is no back-pressure handshake. The requester samples `full`/`empty` before strobing and may issue one operation per cycle.

## Structure
- Shared package `digit_buf_pkg` holds `localparam DIGIT_W = 4` and `localparam DIGIT_DEPTH = 8`, which the UART decoder and display reuse.
- Single module with no sub-modules. The storage is a `reg [WIDTH-1:0] mem [0:DEPTH-1]` array plus an `AW+1`-bit counter. The shift operations use a generate/for loop.
- No `initial` blocks; reset defines all state.

## Test plan
All scenarios use WIDTH=4, DEPTH=8.
- Reset then idle → `data_out` = 32'h0, `count` = 0, `empty` = 1, `full` = 0, `err` = 0.
- Push 1,2,3 on consecutive cycles → `data_out` = 32'h0000_0123, `count` = 3. Then pop → `data_out` = 32'h0000_0012, `count` = 2.
- Push 1..8, then push 9 → after the 8th push `data_out` = 32'h1234_5678 and `full` = 1. The 9th push leaves the contents unchanged with a 1-cycle `err`.
- From `count` = 2 (32'h0000_0012), push and pop together with `wr_data` = 7 → 32'h0000_0017, `count` = 2, `err` = 0. On an empty buffer the same stimulus gives 32'h0000_0007 with `count` = 1.
- `wr_en`, `addr` = 0, `wr_data` = 4'hA on an empty buffer → `data_out` = 32'hA000_0000 with `count` still 0. Then `wr_en` together with `push` → `push` wins and `err` = 1.
- Pop on empty → `err` pulse, state unchanged. Asserting `reset` alongside `push` at `count` = 5 → next cycle all zeros, `count` = 0, `err` = 0.
